// File: rtl/cpu_mul_pipe.sv
// Pipelined integer multiplier for the execute stage.
// Configurable depth, stall/flush control, per-stage hazard scoreboard.
module cpu_mul_pipe #(
  parameter int WIDTH       = 32,
  parameter int NUM_REGS    = 32,
  parameter int STAGES      = 5,
  parameter int ZERO_REG_EN = 1,
  localparam int RD_W       = $clog2(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [1:0]               in_op,
  input  logic [RD_W-1:0]          in_rd,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [RD_W-1:0]          hz_ra,
  input  logic [RD_W-1:0]          hz_rb,
  output logic                     hz_ra_hit,
  output logic                     hz_rb_hit,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*RD_W-1:0]   stage_rd,
  output logic                     busy,
  output logic                     wb_valid,
  output logic [RD_W-1:0]          wb_rd,
  output logic [WIDTH-1:0]         wb_data
);

  localparam logic ZERO_EN = (ZERO_REG_EN != 0);

  logic [STAGES-1:0] r_valid;
  logic [RD_W-1:0]   r_rd  [STAGES];
  logic [WIDTH-1:0]  r_res [STAGES];

  logic               w_sa;
  logic               w_sb;
  logic               w_hi;
  logic [2*WIDTH-1:0] w_ea;
  logic [2*WIDTH-1:0] w_eb;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_hit_a;
  logic               w_hit_b;

  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    w_hi = 1'b1;
    unique case (in_op)
      2'b00: w_hi = 1'b0;
      2'b01: begin
        w_sa = 1'b1;
        w_sb = 1'b1;
      end
      2'b10: w_hi = 1'b1;
      2'b11: w_sa = 1'b1;
    endcase
  end

  // Extending to 2*WIDTH makes a plain unsigned product exact
  // for every signedness combination in its low 2*WIDTH bits.
  assign w_ea = {{WIDTH{w_sa & in_a[WIDTH-1]}}, in_a};
  assign w_eb = {{WIDTH{w_sb & in_b[WIDTH-1]}}, in_b};
  assign w_prod = w_ea * w_eb;
  assign w_res = w_hi ? w_prod[2*WIDTH-1:WIDTH]
                      : w_prod[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_rd[k]  <= '0;
        r_res[k] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (!stall) begin
      r_valid[0] <= in_valid;
      r_rd[0]    <= in_rd;
      r_res[0]   <= w_res;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_rd[k]    <= r_rd[k-1];
        r_res[k]   <= r_res[k-1];
      end
    end
  end

  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (r_valid[k] && (r_rd[k] == hz_ra)) w_hit_a = 1'b1;
      if (r_valid[k] && (r_rd[k] == hz_rb)) w_hit_b = 1'b1;
    end
  end

  assign hz_ra_hit = w_hit_a & ~(ZERO_EN & (hz_ra == '0));
  assign hz_rb_hit = w_hit_b & ~(ZERO_EN & (hz_rb == '0));

  for (genvar k = 0; k < STAGES; k++) begin : g_rd
    assign stage_rd[k*RD_W +: RD_W] = r_rd[k];
  end

  assign stage_valid = r_valid;
  assign busy        = |r_valid;

  assign wb_rd    = r_rd[STAGES-1];
  assign wb_data  = r_res[STAGES-1];
  assign wb_valid = r_valid[STAGES-1] & ~stall & ~flush
                  & ~(ZERO_EN & (r_rd[STAGES-1] == '0));

endmodule

// File: tb/tb_cpu_mul_pipe.sv
// Directed bench for cpu_mul_pipe, 32-bit, 5 stages.
// Inputs change and outputs are sampled on the falling edge.
module tb_cpu_mul_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [4:0]  in_rd;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        stall;
  logic        flush;
  logic [4:0]  hz_ra;
  logic [4:0]  hz_rb;
  logic        hz_ra_hit;
  logic        hz_rb_hit;
  logic [4:0]  stage_valid;
  logic [24:0] stage_rd;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  cpu_mul_pipe #(
    .WIDTH(32), .NUM_REGS(32), .STAGES(5), .ZERO_REG_EN(1)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_op(in_op), .in_rd(in_rd),
    .in_a(in_a), .in_b(in_b),
    .stall(stall), .flush(flush),
    .hz_ra(hz_ra), .hz_rb(hz_rb),
    .hz_ra_hit(hz_ra_hit), .hz_rb_hit(hz_rb_hit),
    .stage_valid(stage_valid), .stage_rd(stage_rd),
    .busy(busy), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    in_valid = 0; in_op = 0; in_rd = 0;
    in_a = 0; in_b = 0; stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    hz_ra = 5'd3; hz_rb = 5'd0;
    checks++;
    if ({wb_valid, wb_rd, wb_data} !== 38'd0) begin
      errors++;
      $display("FAIL reset_wb got v=%0b rd=%0d d=%0h want 0",
               wb_valid, wb_rd, wb_data);
    end
    checks++;
    if ({busy, stage_valid, stage_rd, hz_ra_hit, hz_rb_hit}
        !== 33'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%0b sv=%b hits=%0b%0b want 0",
               busy, stage_valid, hz_ra_hit, hz_rb_hit);
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp_sv;
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c == 0) begin
        in_valid = 1; in_op = 2'b00; in_rd = 5'd3;
        in_a = 32'd7; in_b = 32'd6;
      end
      @(negedge clock);
      exp_sv = (c < 5) ? 5'(1 << c) : 5'd0;
      checks++;
      if (stage_valid !== exp_sv) begin
        errors++;
        $display("FAIL basic_sv c=%0d got %b want %b",
                 c, stage_valid, exp_sv);
      end
      checks++;
      if (wb_valid !== (c == 4)) begin
        errors++;
        $display("FAIL basic_wbv c=%0d got %0b want %0b",
                 c, wb_valid, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (wb_rd !== 5'd3 || wb_data !== 32'd42) begin
          errors++;
          $display("FAIL basic_wb got rd=%0d d=%0d want rd=3 d=42",
                   wb_rd, wb_data);
        end
      end
    end
  endtask

  task automatic test_modes();
    logic [31:0] exp_m [4];
    int j;
    exp_m[0] = 32'hFFFF_FFFA;
    exp_m[1] = 32'hFFFF_FFFF;
    exp_m[2] = 32'h0000_0002;
    exp_m[3] = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c < 4) begin
        in_valid = 1; in_op = 2'(c); in_rd = 5'(10 + c);
        in_a = 32'hFFFF_FFFE; in_b = 32'd3;
      end
      @(negedge clock);
      j = c - 4;
      checks++;
      if (wb_valid !== (j >= 0 && j < 4)) begin
        errors++;
        $display("FAIL modes_wbv c=%0d got %0b", c, wb_valid);
      end
      if (j >= 0 && j < 4) begin
        checks++;
        if (wb_data !== exp_m[j] || wb_rd !== 5'(10 + j)) begin
          errors++;
          $display("FAIL modes_op%0d got rd=%0d d=%h want rd=%0d d=%h",
                   j, wb_rd, wb_data, 10 + j, exp_m[j]);
        end
      end
    end
  endtask

  task automatic test_stall();
    hz_ra = 5'd5; hz_rb = 5'd6;
    for (int c = 0; c < 11; c++) begin
      idle();
      stall = (c >= 3 && c <= 5);
      if (c == 0 || c == 4) begin
        in_valid = 1; in_rd = (c == 0) ? 5'd5 : 5'd6;
        in_a = 32'd3; in_b = 32'd4;
      end
      // sample before the stall of this cycle can mask wb
      @(negedge clock);
      stall = 0;
      #1;
      checks++;
      if (wb_valid !== (c == 7)) begin
        errors++;
        $display("FAIL stall_wbv c=%0d got %0b want %0b",
                 c, wb_valid, (c == 7));
      end
      if (c == 7) begin
        checks++;
        if (wb_rd !== 5'd5 || wb_data !== 32'd12) begin
          errors++;
          $display("FAIL stall_wb got rd=%0d d=%0d want rd=5 d=12",
                   wb_rd, wb_data);
        end
      end
      checks++;
      if (hz_ra_hit !== (c <= 7) || hz_rb_hit !== 1'b0) begin
        errors++;
        $display("FAIL stall_hit c=%0d got a=%0b b=%0b want a=%0b b=0",
                 c, hz_ra_hit, hz_rb_hit, (c <= 7));
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (stage_valid !== 5'b00100) begin
          errors++;
          $display("FAIL stall_hold c=%0d got %b want 00100",
                   c, stage_valid);
        end
      end
    end
  endtask

  task automatic test_stall_mask();
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) begin
        in_valid = 1; in_rd = 5'd8; in_a = 32'd2; in_b = 32'd2;
      end
      @(negedge clock);
    end
    stall = 1;
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_mask got %0b want 0", wb_valid);
    end
    stall = 0;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd4) begin
      errors++;
      $display("FAIL stall_release got v=%0b d=%0d want v=1 d=4",
               wb_valid, wb_data);
    end
    flush = 1;
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_mask got %0b want 0", wb_valid);
    end
    @(negedge clock);
    idle();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 11; c++) begin
      idle();
      if (c < 4) begin
        in_valid = 1; in_rd = 5'(c + 1);
        in_a = 32'd1; in_b = 32'd1;
      end
      if (c == 3) begin
        flush = 1; stall = 1;
      end
      if (c == 5) begin
        in_valid = 1; in_rd = 5'd7;
        in_a = 32'd9; in_b = 32'd9;
      end
      @(negedge clock);
      checks++;
      if (wb_valid !== (c == 9)) begin
        errors++;
        $display("FAIL flush_wbv c=%0d got %0b want %0b",
                 c, wb_valid, (c == 9));
      end
      if (c == 3) begin
        checks++;
        if (busy !== 1'b0 || stage_valid !== 5'd0) begin
          errors++;
          $display("FAIL flush_busy got busy=%0b sv=%b want 0",
                   busy, stage_valid);
        end
      end
      if (c == 9) begin
        checks++;
        if (wb_rd !== 5'd7 || wb_data !== 32'd81) begin
          errors++;
          $display("FAIL flush_after got rd=%0d d=%0d want rd=7 d=81",
                   wb_rd, wb_data);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    hz_ra = 5'd0; hz_rb = 5'd9;
    for (int c = 0; c < 10; c++) begin
      idle();
      in_valid = (c == 0 || c == 2 || c == 3);
      in_rd = (c == 0) ? 5'd0 : 5'd9;
      in_a = (c == 3) ? 32'd4 : 32'd2;
      in_b = (c == 3) ? 32'd5 : 32'd3;
      @(negedge clock);
      if (c == 0) begin
        checks++;
        if (stage_valid !== 5'b00001) begin
          errors++;
          $display("FAIL zero_sv got %b want 00001", stage_valid);
        end
      end
      checks++;
      if (hz_ra_hit !== 1'b0) begin
        errors++;
        $display("FAIL zero_hit c=%0d got %0b want 0", c, hz_ra_hit);
      end
      checks++;
      if (hz_rb_hit !== (c >= 2 && c <= 7)) begin
        errors++;
        $display("FAIL zero_hitb c=%0d got %0b want %0b",
                 c, hz_rb_hit, (c >= 2 && c <= 7));
      end
      checks++;
      if (wb_valid !== (c == 6 || c == 7)) begin
        errors++;
        $display("FAIL zero_wbv c=%0d got %0b", c, wb_valid);
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (wb_rd !== 5'd9 ||
            wb_data !== ((c == 6) ? 32'd6 : 32'd20)) begin
          errors++;
          $display("FAIL zero_b2b c=%0d got rd=%0d d=%0d",
                   c, wb_rd, wb_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    hz_ra = 5'd2; hz_rb = 5'd3;
    for (int c = 0; c < 3; c++) begin
      idle();
      in_valid = 1; in_rd = 5'(c + 1);
      in_a = 32'd5; in_b = 32'd5;
      @(negedge clock);
    end
    checks++;
    if (busy !== 1'b1 || stage_valid !== 5'b00111) begin
      errors++;
      $display("FAIL rmid_pre got busy=%0b sv=%b want 1 00111",
               busy, stage_valid);
    end
    idle();
    reset = 1; stall = 1; flush = 1;
    @(negedge clock);
    reset = 0; stall = 0; flush = 0;
    #1;
    checks++;
    if ({busy, stage_valid, stage_rd, hz_ra_hit, hz_rb_hit,
         wb_valid, wb_rd, wb_data} !== 71'd0) begin
      errors++;
      $display("FAIL rmid_clear got busy=%0b sv=%b wb=%0b d=%h",
               busy, stage_valid, wb_valid, wb_data);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      checks++;
      if (wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_wb c=%0d got %0b want 0", c, wb_valid);
      end
    end
  endtask

  initial begin
    idle();
    reset = 1; hz_ra = 0; hz_rb = 0;
    @(negedge clock);
    @(negedge clock);
    test_reset();
    reset = 0;
    @(negedge clock);
    test_basic();
    test_modes();
    test_stall();
    test_stall_mask();
    test_flush();
    test_zero_reg();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mul_pipe.md
Name: cpu_mul_pipe

Overview:
Parametrised pipelined integer multiplier for the execute stage. It generalises the fixed 5-stage low-word multiply to configurable width, depth and multiply mode (low, signed/unsigned/mixed high). It adds stall/flush control and a per-stage scoreboard for the hazard detection unit. Results retire through a dedicated multiplier write-back port to the register bank.

Parameters:
WIDTH, 32, operand and result width in bits
NUM_REGS, 32, architectural register count; RD_W = $clog2(NUM_REGS)
STAGES, 5, pipeline depth (issue-to-writeback latency in cycles), legal range 1..8
ZERO_REG_EN, 1, when 1 register 0 never reports a hazard hit and is never written

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
in_valid  in  1  issue a multiply this cycle
in_op  in  2  00 MUL low word, 01 MULH s×s high, 10 MULHU u×u high, 11 MULHSU s×u high
in_rd  in  RD_W  destination register
in_a  in  WIDTH  operand A (already forwarded)
in_b  in  WIDTH  operand B (already forwarded)
stall  in  1  freeze all stages
flush  in  1  kill every in-flight and issuing op
hz_ra  in  RD_W  hazard query A
hz_rb  in  RD_W  hazard query B
hz_ra_hit  out  1  hz_ra matches a valid in-flight rd
hz_rb_hit  out  1  hz_rb matches a valid in-flight rd
stage_valid  out  STAGES  valid bit per stage, bit 0 youngest
stage_rd  out  STAGES*RD_W  rd per stage, slice k = stage k
busy  out  1  OR of stage_valid
wb_valid  out  1  write-back strobe
wb_rd  out  RD_W  write-back register
wb_data  out  WIDTH  write-back value

Behaviour:
- Stage registers S[0..STAGES-1], each holding {valid, rd, result}.
- S[0] loads at an edge where in_valid=1, stall=0 and flush=0. Result is computed at issue:
  - op 00: low WIDTH bits of a×b.
  - op 01/10/11: high WIDTH bits of the 2·WIDTH product, with A and B sign-extended or zero-extended per op.
  - S[k] loads from S[k-1] on each non-stalled edge.
- Latency: for an op sampled at edge t, wb_valid=1 during the cycle after edge t+STAGES-1. Exactly one wb_valid cycle per op.
- Output drive:
  - wb_valid = S[STAGES-1].valid & ~stall & ~flush.
  - wb_rd and wb_data are driven from S[STAGES-1].
  - When ZERO_REG_EN=1 and rd=0, wb_valid is forced to 0.
- Stall:
  - All S hold.
  - in_valid is ignored; re-issue is the issuer's job.
  - wb_valid=0 for the whole stall. The held result writes once in the first unstalled cycle.
- Flush:
  - Clears every S.valid at the next edge, including the op issuing that cycle.
  - wb_valid=0 in the flush cycle.
  - Flush has priority over stall.
- Hazard query:
  - hz_rX_hit = OR over k of (S[k].valid & S[k].rd==hz_rX).
  - The query is combinational and does not include the op issuing in the same cycle.
  - Forced to 0 for register 0 when ZERO_REG_EN=1.
- Back-to-back issue with the same rd is legal. Ops retire in order, so the youngest value is the last written.
- Reset:
  - All S.valid, rd and result clear to 0, so wb_valid=0, wb_rd=0, wb_data=0, busy=0, hazard hits 0.
  - Reset mid-operation discards all in-flight ops with no write-back.
  - Reset has priority over flush and stall.
- STAGES=1: S[0] is the output stage. wb_valid appears the cycle after issue.

Test Plan:
- Reset, then issue MUL rd=3, a=7, b=6 with STAGES=5 → wb_valid=1, wb_rd=3, wb_data=42 exactly 5 cycles later for one cycle; stage_valid walks 00001→10000.
- Issue one op of each mode, a=0xFFFFFFFE, b=3, WIDTH=32 → low=0xFFFFFFFA, MULH=0xFFFFFFFF, MULHU=0x00000002, MULHSU=0xFFFFFFFF.
- Issue rd=5, then stall 3 cycles when the op sits in S[2] → wb_valid delayed exactly 3 cycles and pulses once; hz_ra=5 hit stays 1 throughout.
- Issue 4 back-to-back ops to rd=1..4, assert flush one cycle when the first reaches S[2] → no wb_valid for any of them; busy=0 next cycle; a later op retires normally.
- Issue rd=0 with ZERO_REG_EN=1 and hz_ra=0 → hz_ra_hit=0 and no wb_valid; then issue rd=9 and rd=9 again → two wb pulses in consecutive cycles, second value last.
- Assert reset with 3 ops in flight plus stall=1 and flush=1 → all outputs 0 the next cycle, no write-back follows.
